otter_mem_arbiter: RTL and testbench

Shares the single OTTER memory port between the instruction-fetch requester (port I, read-only) and the data-access requester (port D, read/write). It arbitrates, registers the winning request, and drives the shared address/data mux select (mem_sel). It sequences exactly one outstanding memory transaction at a time. It sits between the pipeline's IF/MEM stages and the memory or cache controller.

---
 rtl/otter_mem_pkg.sv | 28 ++
 rtl/otter_arb_starve_cnt.sv | 41 ++++
 rtl/otter_mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_otter_mem_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_mem_pkg.sv
// Shared types for the OTTER memory-port arbiter.
// Holds the FSM encoding, mux-select codes and the latched request bundle.
package otter_mem_pkg;

    // Widest address/data the latched request bundle can hold
    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BE_W   = MEM_DATA_W / 8;

    // Shared address/data mux select codes
    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY_I,
        ARB_BUSY_D
    } arb_state_t;

    // Request fields frozen for the duration of one memory transaction
    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic                  we;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_BE_W-1:0]   be;
    } mem_req_t;

endpackage

// File: rtl/otter_arb_starve_cnt.sv
// Saturating wait counter for the instruction port of the memory arbiter.
// sat flags that port I has waited LIMIT cycles and must win the next arbitration.
module otter_arb_starve_cnt #(
    parameter int LIMIT = 8
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int             CW    = $clog2(LIMIT + 1);
    localparam logic [CW-1:0]  LIM_C = CW'(LIMIT);
    localparam logic [CW-1:0]  ONE_C = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over increment; increment stops at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIM_C)) begin
            cnt_d = cnt_q + ONE_C;
        end
    end

    // Counter register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == LIM_C);

endmodule

// File: rtl/otter_mem_arbiter.sv
// Two-port (fetch / data) arbiter for the single OTTER memory port, one transaction in flight.
// Optional macro OTTER_MEM_ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed D priority.
module otter_mem_arbiter
    import otter_mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_sel,
    output logic                busy
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t state_q;
    arb_state_t state_d;
    mem_req_t   req_q;
    mem_req_t   req_d;
    logic       sel_q;
    logic       sel_d;

    logic       grant_i;
    logic       grant_d;
    logic       pick_i;
    logic       starve_sat;
    logic       starve_inc;
    logic       starve_clr;

`ifdef OTTER_MEM_ARB_ROUND_ROBIN_EN
    logic       last_q;
    logic       last_d;

    // On contention the port not served last wins; starvation still forces I
    always_comb begin
        pick_i = starve_sat | (last_q == SEL_D);
    end
`else
    // On contention D wins unless I has been starved
    always_comb begin
        pick_i = starve_sat;
    end
`endif

    // Grant decision, only taken while no transaction is in flight
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == ARB_IDLE) begin
            if (i_req && d_req) begin
                grant_i = pick_i;
                grant_d = ~pick_i;
            end else begin
                grant_i = i_req;
                grant_d = d_req;
            end
        end
    end

    // Next state and latched request fields
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        sel_d   = sel_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_i) begin
                    state_d     = ARB_BUSY_I;
                    sel_d       = SEL_I;
                    req_d.addr  = MEM_ADDR_W'(i_addr);
                    req_d.we    = 1'b0;
                    req_d.wdata = '0;
                    req_d.be    = '1;
                end else if (grant_d) begin
                    state_d     = ARB_BUSY_D;
                    sel_d       = SEL_D;
                    req_d.addr  = MEM_ADDR_W'(d_addr);
                    req_d.we    = d_we;
                    req_d.wdata = MEM_DATA_W'(d_wdata);
                    req_d.be    = d_we ? MEM_BE_W'(d_be) : '1;
                end
            end
            ARB_BUSY_I,
            ARB_BUSY_D: begin
                if (mem_ack) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and latched-request registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ARB_IDLE;
            req_q   <= '0;
            sel_q   <= SEL_I;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            sel_q   <= sel_d;
        end
    end

`ifdef OTTER_MEM_ARB_ROUND_ROBIN_EN
    // Remember which port was granted most recently
    always_comb begin
        last_d = last_q;
        if (grant_i) begin
            last_d = SEL_I;
        end else if (grant_d) begin
            last_d = SEL_D;
        end
    end

    // Last-grant register, resets to I so D wins the first contention
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_q <= SEL_I;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // I waits in any cycle it requests without being granted
    always_comb begin
        starve_inc = i_req & ~grant_i;
        starve_clr = ~i_req | grant_i;
    end

    otter_arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .sat   (starve_sat)
    );

    // Memory-side outputs come straight from registers; acks qualify shared rdata
    always_comb begin
        busy      = (state_q != ARB_IDLE);
        mem_req   = busy;
        mem_sel   = sel_q;
        mem_we    = req_q.we;
        mem_addr  = ADDR_W'(req_q.addr);
        mem_wdata = DATA_W'(req_q.wdata);
        mem_be    = BE_W'(req_q.be);
        i_ack     = (state_q == ARB_BUSY_I) & mem_ack;
        d_ack     = (state_q == ARB_BUSY_D) & mem_ack;
        i_rdata   = mem_rdata;
        d_rdata   = mem_rdata;
    end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Self-checking bench for otter_mem_arbiter: directed steps plus a random phase
// against a transaction-level reference model of the arbitration rules.
module tb_otter_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = 4;
    localparam int LIM = 8;

`ifdef OTTER_MEM_ARB_ROUND_ROBIN_EN
    localparam int EXP_ND = 1;
`else
    localparam int EXP_ND = 4;
`endif

    logic          CLK;
    logic          RST_N;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [BW-1:0] d_be;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          mem_sel;
    logic          busy;

    otter_mem_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_sel   (mem_sel),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = idle, 1 = serving I, 2 = serving D
    int            m_st;
    int            m_wait;
    bit            m_last_d;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [DW-1:0] m_wdata;
    logic [BW-1:0] m_be;
    logic          m_sel;
    int            lat;
    int            fix_lat;
    bit            rd_fixed;
    logic [DW-1:0] rd_val;
    bit            i_auto;
    bit            d_auto;

    logic          o_iack;
    logic          o_dack;
    logic [DW-1:0] o_irdata;
    logic [DW-1:0] o_drdata;
    logic          o_req;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st     = 0;
        m_wait   = 0;
        m_last_d = 1'b0;
        m_addr   = '0;
        m_we     = 1'b0;
        m_wdata  = '0;
        m_be     = '0;
        m_sel    = 1'b0;
        lat      = 0;
    endtask

    task automatic new_d();
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_be    = 4'($urandom);
    endtask

    // One clock cycle: drive memory, check outputs, advance model, handle requester side
    task automatic cycle();
        logic ea_i;
        logic ea_d;
        logic win_i;
        logic win_d;
        logic pick;
        mem_ack   = (m_st != 0) && (lat == 0);
        mem_rdata = rd_fixed ? rd_val : $urandom;
        #1;
        ea_i = (m_st == 1) && mem_ack;
        ea_d = (m_st == 2) && mem_ack;
        chk("mem_req", mem_req, m_st != 0);
        chk("busy", busy, m_st != 0);
        chk("i_ack", i_ack, ea_i);
        chk("d_ack", d_ack, ea_d);
        chk("i_rdata", i_rdata, mem_rdata);
        chk("d_rdata", d_rdata, mem_rdata);
        if (m_st != 0) begin
            chk("mem_sel", mem_sel, m_sel);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", mem_we, m_we);
            chk("mem_be", mem_be, m_be);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        o_iack   = i_ack;
        o_dack   = d_ack;
        o_irdata = i_rdata;
        o_drdata = d_rdata;
        o_req    = mem_req;
        win_i = 1'b0;
        win_d = 1'b0;
        if (m_st == 0) begin
            if (i_req && d_req) begin
                pick = (m_wait == LIM);
`ifdef OTTER_MEM_ARB_ROUND_ROBIN_EN
                pick = pick || m_last_d;
`endif
                win_i = pick;
                win_d = !pick;
            end else begin
                win_i = i_req;
                win_d = d_req;
            end
            if (win_i) begin
                m_st = 1; m_addr = i_addr; m_we = 1'b0;
                m_wdata = '0; m_be = '1; m_sel = 1'b0; m_last_d = 1'b0;
            end else if (win_d) begin
                m_st = 2; m_addr = d_addr; m_we = d_we;
                m_wdata = d_wdata; m_be = d_we ? d_be : 4'hF;
                m_sel = 1'b1; m_last_d = 1'b1;
            end
            if (win_i || win_d) lat = (fix_lat >= 0) ? fix_lat : $urandom_range(0, 3);
        end else if (mem_ack) begin
            m_st = 0;
        end else begin
            lat--;
        end
        if (!i_req || win_i) m_wait = 0;
        else if (m_wait < LIM) m_wait++;
        @(posedge CLK);
        #1;
        if (ea_i) begin
            if (i_auto) i_addr = $urandom;
            else i_req = 1'b0;
        end
        if (ea_d) begin
            if (d_auto) new_d();
            else d_req = 1'b0;
        end
    endtask

    initial begin
        int nd;
        bit got_i;
        logic prev;
        logic [3:0] seq;
        int ng;
        RST_N = 1'b0;
        i_req = 0; i_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
        mem_ack = 0; mem_rdata = '0;
        fix_lat = -1; rd_fixed = 0; rd_val = '0;
        i_auto = 0; d_auto = 0;
        model_reset();
        #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_be", mem_be, 4'h0);
        chk("rst_mem_sel", mem_sel, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_acks", {i_ack, d_ack}, 2'b00);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // Lone fetch with a two-cycle memory
        i_req = 1; i_addr = 32'h0000_0100;
        rd_fixed = 1; rd_val = 32'h0000_0013; fix_lat = 1;
        cycle();
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_we", mem_we, 1'b0);
        chk("t1_be", mem_be, 4'hF);
        chk("t1_sel", mem_sel, 1'b0);
        cycle();
        chk("t1_no_early_ack", o_iack, 1'b0);
        cycle();
        chk("t1_iack", o_iack, 1'b1);
        chk("t1_rdata", o_irdata, 32'h13);
        chk("t1_dack", o_dack, 1'b0);
        cycle();
        chk("t1_pulse", o_iack, 1'b0);
        chk("t1_idle", o_req, 1'b0);
        rd_fixed = 0;

        // Simultaneous requests: D first, then I after one idle bubble
        fix_lat = 0;
        i_req = 1; i_addr = 32'h200;
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
        cycle();
        chk("t2_sel_d", mem_sel, 1'b1);
        chk("t2_we", mem_we, 1'b1);
        chk("t2_be", mem_be, 4'h3);
        chk("t2_wdata", mem_wdata, 32'hDEADBEEF);
        chk("t2_addr", mem_addr, 32'h2000);
        cycle();
        chk("t2_dack", o_dack, 1'b1);
        cycle();
        chk("t2_bubble", o_req, 1'b0);
        chk("t2_sel_i", mem_sel, 1'b0);
        chk("t2_addr_i", mem_addr, 32'h200);
        cycle();
        chk("t2_iack", o_iack, 1'b1);
        cycle();

        // Starvation: both held, zero-wait memory
        i_auto = 1; d_auto = 1;
        i_req = 1; i_addr = $urandom;
        d_req = 1; new_d();
        nd = 0; got_i = 0; prev = mem_req;
        for (int k = 0; k < 40 && !got_i; k++) begin
            cycle();
            if (mem_req && !prev) begin
                if (mem_sel == 1'b0) got_i = 1;
                else nd++;
            end
            prev = mem_req;
        end
        chk("t3_i_granted", got_i, 1'b1);
        chk("t3_d_before_i", 64'(nd), 64'(EXP_ND));
        got_i = 0;
        for (int k = 0; k < 6 && !got_i; k++) begin
            cycle();
            if (mem_req && !prev) begin
                got_i = 1;
                chk("t3_next_is_d", mem_sel, 1'b1);
            end
            prev = mem_req;
        end
        chk("t3_next_seen", got_i, 1'b1);
        i_auto = 0; d_auto = 0;
        for (int k = 0; k < 10; k++) cycle();

        // Zero-wait memory, alternating single requests
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                i_req = 1; i_addr = $urandom;
            end else begin
                d_req = 1; new_d();
            end
            cycle();
            chk("t4_idle_gap", o_req, 1'b0);
            cycle();
            chk("t4_ack", (k % 2 == 0) ? o_iack : o_dack, 1'b1);
        end

        // Reset in the middle of a data transaction
        d_req = 1; d_we = 0; d_addr = 32'h3000; fix_lat = 3;
        cycle();
        chk("t5_busy", busy, 1'b1);
        mem_ack = 1;
        #2;
        RST_N = 0;
        #1;
        chk("t5_mem_req", mem_req, 1'b0);
        chk("t5_busy_clr", busy, 1'b0);
        chk("t5_dack", d_ack, 1'b0);
        chk("t5_be", mem_be, 4'h0);
        mem_ack = 0; d_req = 0;
        @(posedge CLK);
        #1;
        RST_N = 1;
        model_reset();
        fix_lat = 0;
        d_req = 1; d_we = 1; d_addr = 32'h3004; d_wdata = $urandom; d_be = 4'hC;
        cycle();
        cycle();
        chk("t5_fresh_dack", o_dack, 1'b1);
        cycle();

`ifdef OTTER_MEM_ARB_ROUND_ROBIN_EN
        // Round robin after reset: D, I, D, I
        RST_N = 0;
        #2;
        RST_N = 1;
        model_reset();
        i_auto = 1; d_auto = 1;
        i_req = 1; i_addr = $urandom;
        d_req = 1; new_d();
        ng = 0; seq = '0; prev = 1'b0;
        for (int k = 0; k < 20 && ng < 4; k++) begin
            cycle();
            if (mem_req && !prev) begin
                seq[3-ng] = mem_sel;
                ng++;
            end
            prev = mem_req;
        end
        chk("t6_rr_seq", seq, 4'b1010);
        i_auto = 0; d_auto = 0;
        for (int k = 0; k < 10; k++) cycle();
`endif

        // Random traffic with random memory latency
        fix_lat = -1;
        for (int k = 0; k < 400; k++) begin
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1; i_addr = $urandom;
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; new_d();
            end
            i_auto = 1'($urandom_range(0, 1));
            d_auto = 1'($urandom_range(0, 1));
            cycle();
        end
        i_auto = 0; d_auto = 0;
        for (int k = 0; k < 20; k++) cycle();
        chk("drain_idle", mem_req, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
